// File: rtl/riscv_pkg.sv
// Shared RISC-V core constants and the fetch-queue entry layout.
package riscv_pkg;

    localparam int          XLEN     = 32;
    localparam logic [31:0] INST_NOP = 32'h0000_0013;
    localparam logic [31:0] PC_STEP  = 32'd4;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous circular FIFO; flush empties it in one cycle, a full FIFO accepts a push alongside a pop.
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wr_data,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW:0]      count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + (PW+1)'(push) - (PW+1)'(pop);
        if (push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: stale entries are never visible because count gates the head.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wr_data;
    end

    assign full  = (count_q == (PW+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/inst_fetch_buffer.sv
// Instruction prefetch queue: sequential fetch from inst_mem, buffered hand-off to decode, redirect flush.
module inst_fetch_buffer
    import riscv_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_inst,
    output logic        out_valid,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc,
    input  logic        out_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);

    logic [31:0]  fetch_pc_q, fetch_pc_d;
    logic         push, pop, full, empty;
    fetch_entry_t head, wr_entry;

    // A redirect cancels any handshake in its cycle, so the head is never consumed then.
    assign pop  = ~empty & out_ready & ~redirect_valid;
    assign push = ~redirect_valid & (~full | pop);

    assign wr_entry.pc   = fetch_pc_q;
    assign wr_entry.inst = mem_inst;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        if (redirect_valid) begin
            fetch_pc_d = {redirect_pc[31:2], 2'b00};
        end else if (push) begin
            fetch_pc_d = fetch_pc_q + PC_STEP;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
        end else begin
            fetch_pc_q <= fetch_pc_d;
        end
    end

    fetch_fifo #(
        .WIDTH($bits(fetch_entry_t)),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .push   (push),
        .pop    (pop),
        .flush  (redirect_valid),
        .wr_data(wr_entry),
        .full   (full),
        .empty  (empty),
        .head   (head)
    );

    assign mem_addr  = fetch_pc_q;
    assign out_valid = ~empty;
    assign out_inst  = out_valid ? head.inst : '0;
    assign out_pc    = out_valid ? head.pc   : '0;

endmodule

// File: tb/tb_inst_fetch_buffer.sv
// Self-checking bench: directed vector table, random run against a queue model, reset-PC wrap sequence.
module tb_inst_fetch_buffer;

    localparam int          DEPTH      = 4;
    localparam logic [31:0] RESET_PC_A = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_B = 32'hFFFF_FFF8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstA, outReadyA, redirValidA, outValidA;
    logic [31:0] redirPcA, memAddrA, memInstA, outInstA, outPcA;
    logic        rstB, outReadyB, redirValidB, outValidB;
    logic [31:0] redirPcB, memAddrB, memInstB, outInstB, outPcB;

    int checks = 0;
    int errors = 0;

    function automatic logic [31:0] memWord(input logic [31:0] addr);
        return addr ^ 32'h5A5A_0013;
    endfunction

    assign memInstA = memWord(memAddrA);
    assign memInstB = memWord(memAddrB);

    inst_fetch_buffer #(.DEPTH(DEPTH), .RESET_PC(RESET_PC_A)) dutA (
        .clk(clk), .rst(rstA), .mem_addr(memAddrA), .mem_inst(memInstA),
        .out_valid(outValidA), .out_inst(outInstA), .out_pc(outPcA),
        .out_ready(outReadyA), .redirect_valid(redirValidA), .redirect_pc(redirPcA)
    );

    inst_fetch_buffer #(.DEPTH(DEPTH), .RESET_PC(RESET_PC_B)) dutB (
        .clk(clk), .rst(rstB), .mem_addr(memAddrB), .mem_inst(memInstB),
        .out_valid(outValidB), .out_inst(outInstB), .out_pc(outPcB),
        .out_ready(outReadyB), .redirect_valid(redirValidB), .redirect_pc(redirPcB)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } entry_t;

    entry_t      modelQ[$];
    logic [31:0] modelFetch = RESET_PC_A;

    typedef struct {
        logic        rst;
        logic        redir;
        logic [31:0] rpc;
        logic        ready;
        logic        expValid;
        logic [31:0] expPc;
        logic [31:0] expAddr;
    } vec_t;

    vec_t vecs[18];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic red, input logic [31:0] rpc, input logic rdy);
        rstA        = r;
        redirValidA = red;
        redirPcA    = rpc;
        outReadyA   = rdy;
    endtask

    // Queue-level reference: pop first, then fill whatever space remains, one fetch per cycle.
    task automatic modelStep(input logic r, input logic red, input logic [31:0] rpc, input logic rdy);
        entry_t e;
        if (r) begin
            modelQ.delete();
            modelFetch = RESET_PC_A;
        end else if (red) begin
            modelQ.delete();
            modelFetch = rpc & ~32'h3;
        end else begin
            if (modelQ.size() != 0 && rdy) void'(modelQ.pop_front());
            if (modelQ.size() < DEPTH) begin
                e.pc   = modelFetch;
                e.inst = memWord(modelFetch);
                modelQ.push_back(e);
                modelFetch = modelFetch + 32'd4;
            end
        end
    endtask

    task automatic compareModel(input string tag);
        logic        v;
        logic [31:0] p, ins;
        v   = (modelQ.size() != 0);
        p   = v ? modelQ[0].pc   : 32'h0;
        ins = v ? modelQ[0].inst : 32'h0;
        checkOutput({tag, " valid"},    {31'h0, outValidA}, {31'h0, v});
        checkOutput({tag, " pc"},       outPcA,   p);
        checkOutput({tag, " inst"},     outInstA, ins);
        checkOutput({tag, " mem_addr"}, memAddrA, modelFetch);
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [31:0] prevPc;
        logic [31:0] bPc[6];
        logic        bValid[6];
        logic [31:0] bAddr[6];
        logic        bRst[6];

        // rst, redir, rpc, ready, expValid, expPc, expAddr
        vecs[0]  = '{1'b1, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   32'h0};
        vecs[1]  = '{1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   32'h0};
        vecs[2]  = '{1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 32'h0,   32'h4};
        vecs[3]  = '{1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 32'h0,   32'h8};
        vecs[4]  = '{1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 32'h0,   32'hC};
        vecs[5]  = '{1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 32'h0,   32'h10};
        vecs[6]  = '{1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 32'h0,   32'h10};
        vecs[7]  = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h0,   32'h10};
        vecs[8]  = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h4,   32'h14};
        vecs[9]  = '{1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 32'h8,   32'h18};
        vecs[10] = '{1'b0, 1'b1, 32'h103, 1'b1, 1'b1, 32'h8,   32'h18};
        vecs[11] = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,   32'h100};
        vecs[12] = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h100, 32'h104};
        vecs[13] = '{1'b0, 1'b1, 32'h200, 1'b1, 1'b1, 32'h104, 32'h108};
        vecs[14] = '{1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   32'h200};
        vecs[15] = '{1'b1, 1'b0, 32'h0,   1'b1, 1'b1, 32'h200, 32'h204};
        vecs[16] = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,   32'h0};
        vecs[17] = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h0,   32'h4};

        rstB = 1'b1; outReadyB = 1'b1; redirValidB = 1'b0; redirPcB = 32'h0;
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
        repeat (2) begin
            @(posedge clk);
            modelStep(1'b1, 1'b0, 32'h0, 1'b0);
        end

        for (int i = 0; i < 18; i++) begin
            logic [31:0] expInst;
            @(negedge clk);
            applyStimulus(vecs[i].rst, vecs[i].redir, vecs[i].rpc, vecs[i].ready);
            #1;
            expInst = vecs[i].expValid ? memWord(vecs[i].expPc) : 32'h0;
            checkOutput($sformatf("vec%0d valid", i), {31'h0, outValidA}, {31'h0, vecs[i].expValid});
            checkOutput($sformatf("vec%0d pc", i), outPcA, vecs[i].expPc);
            checkOutput($sformatf("vec%0d inst", i), outInstA, expInst);
            checkOutput($sformatf("vec%0d mem_addr", i), memAddrA, vecs[i].expAddr);
            @(posedge clk);
            modelStep(vecs[i].rst, vecs[i].redir, vecs[i].rpc, vecs[i].ready);
        end

        // Fill the queue, then stream for 20 cycles with push and pop together.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
            #1;
            compareModel($sformatf("fill%0d", i));
            @(posedge clk);
            modelStep(1'b0, 1'b0, 32'h0, 1'b0);
        end
        prevPc = outPcA;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
            #1;
            compareModel($sformatf("stream%0d", i));
            if (i > 0) checkOutput($sformatf("stream%0d step", i), outPcA, prevPc + 32'd4);
            prevPc = outPcA;
            @(posedge clk);
            modelStep(1'b0, 1'b0, 32'h0, 1'b1);
        end

        for (int i = 0; i < 500; i++) begin
            logic        r, red, rdy;
            logic [31:0] rpc;
            r   = ($urandom_range(0, 99) < 2);
            red = ($urandom_range(0, 99) < 6);
            rdy = ($urandom_range(0, 99) < 65);
            rpc = $urandom;
            @(negedge clk);
            applyStimulus(r, red, rpc, rdy);
            #1;
            compareModel($sformatf("rand%0d", i));
            @(posedge clk);
            modelStep(r, red, rpc, rdy);
        end

        // Fetch PC wraps past 0xFFFF_FFFC; a mid-stream reset returns to RESET_PC.
        bRst   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        bValid = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        bPc    = '{32'h0, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h4, 32'h0};
        bAddr  = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h4, 32'h8, 32'hFFFF_FFF8};
        @(negedge clk);
        #1;
        checkOutput("wrap reset valid", {31'h0, outValidB}, 32'h0);
        checkOutput("wrap reset mem_addr", memAddrB, RESET_PC_B);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            rstB = bRst[i];
            #1;
            checkOutput($sformatf("wrap%0d valid", i), {31'h0, outValidB}, {31'h0, bValid[i]});
            checkOutput($sformatf("wrap%0d pc", i), outPcB, bPc[i]);
            checkOutput($sformatf("wrap%0d inst", i), outInstB, bValid[i] ? memWord(bPc[i]) : 32'h0);
            checkOutput($sformatf("wrap%0d mem_addr", i), memAddrB, bAddr[i]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
